fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_queue.sv | 188 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding, default constants and helpers for the fetch queue.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } fetch_state_e;

    localparam int unsigned PC_STEP  = 32'd4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0000;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction store with wrap-bit pointers and a single-cycle flush.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             wr_fire_s;
    logic             rd_fire_s;

    // Equal pointers mean empty; same index with opposite wrap bits means full.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign wr_fire_s = wr_en_i && !full_o && !flush_i;
    assign rd_fire_s = rd_en_i && !empty_o && !flush_i;

    // Pointer next-state: flush clears both, otherwise advance on each fire.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_fire_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, cleared on reset so no stale content is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_fire_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC sequencing, one outstanding imem request, decoupling queue.
// Define FETCH_QUEUE_PERF_EN to add the perf_fetched/perf_flushed counters.
module fetch_queue #(
    parameter int unsigned  N        = 64,
    parameter int unsigned  INST_W   = 32,
    parameter int unsigned  DEPTH    = 4,
    parameter int unsigned  PC_STEP  = fetch_pkg::PC_STEP,
    parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrc_F,
    input  logic [N-1:0]      PCBranch_F,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [N-1:0]      imem_addr_F,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [N-1:0]      inst_pc
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    import fetch_pkg::*;

    localparam int unsigned  AW      = $clog2(DEPTH);
    localparam int unsigned  EW      = N + INST_W;
    localparam logic [N-1:0] STEP    = N'(PC_STEP);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [N-1:0]  pc_q;
    logic [N-1:0]  pc_d;
    logic          inflight_q;
    logic          inflight_d;
    logic [N-1:0]  inflight_pc_q;
    logic [N-1:0]  inflight_pc_d;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          enq_s;
    logic          deq_s;
    logic [AW:0]   count_s;
    logic [AW+1:0] occ_s;
    logic          empty_s;
    logic          full_s;
    logic [EW-1:0] head_s;

    // In-flight request reserves a slot so its response always has room.
    assign occ_s      = {1'b0, count_s} + {{(AW+1){1'b0}}, inflight_q};
    assign req_fire_s = req_valid_s && imem_req_ready;

    // Request gating: no request during reset, on a redirect, or without a free slot.
    always_comb begin
        if (reset && !PCSrc_F && (occ_s < DEPTH_W)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Enqueue/dequeue qualification; a redirect kills the coincident response.
    always_comb begin
        enq_s = 1'b0;
        deq_s = 1'b0;
        if (PCSrc_F) begin
            enq_s = 1'b0;
            deq_s = 1'b0;
        end else begin
            enq_s = imem_rsp_valid && inflight_q && (state_q == RUN) && !full_s;
            deq_s = !empty_s && inst_ready;
        end
    end

    // Redirect tracking FSM: REDIR marks the single cycle following a redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (PCSrc_F) begin
                    state_d = REDIR;
                end else begin
                    state_d = RUN;
                end
            end
            REDIR: begin
                if (PCSrc_F) begin
                    state_d = REDIR;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Next PC select and in-flight tag capture.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = req_fire_s;
        inflight_pc_d = inflight_pc_q;
        if (PCSrc_F) begin
            pc_d = PCBranch_F;
        end else if (req_fire_s) begin
            pc_d = pc_q + STEP;
        end else begin
            pc_d = pc_q;
        end
        if (req_fire_s) begin
            inflight_pc_d = pc_q;
        end else begin
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {N{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush_i   (PCSrc_F),
        .wr_en_i   (enq_s),
        .wr_data_i ({inflight_pc_q, imem_rsp_data}),
        .rd_en_i   (deq_s),
        .rd_data_o (head_s),
        .empty_o   (empty_s),
        .full_o    (full_s),
        .count_o   (count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_addr_F    = pc_q;
    assign inst_valid     = !empty_s;
    assign inst_pc        = head_s[EW-1:INST_W];
    assign inst_data      = head_s[INST_W-1:0];

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] flush_amt_s;

    // Entries lost on a redirect: queued ones plus the response being killed.
    always_comb begin
        if (PCSrc_F) begin
            flush_amt_s = 32'(count_s) + 32'(inflight_q);
        end else begin
            flush_amt_s = 32'd0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= sat_add32(perf_fetched_q, {31'd0, req_fire_s});
            perf_flushed_q <= sat_add32(perf_flushed_q, flush_amt_s);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against a queue-level reference model.
module tb_fetch_queue;

    localparam int          N      = 64;
    localparam int          INST_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          STEP   = 4;
    localparam logic [63:0] RST_PC = 64'h100;

    logic              clk = 1'b0;
    logic              reset;
    logic              PCSrc_F;
    logic [N-1:0]      PCBranch_F;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [N-1:0]      imem_addr_F;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [N-1:0]      inst_pc;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .N(N), .INST_W(INST_W), .DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr_F(imem_addr_F), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_QUEUE_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    typedef struct {
        logic        req_valid;
        logic [63:0] addr;
        logic        inst_valid;
        logic        zero_chk;
    } cyc_exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } ent_t;

    cyc_exp_t cyc_q[$];
    ent_t     deq_q[$];
    int       n_vec = 0;
    int       n_err = 0;

    ent_t            m_q[$];
    logic [63:0]     m_pc;
    bit              m_inflight;
    logic [63:0]     m_inflight_pc;
    longint unsigned m_fetched;
    longint unsigned m_flushed;
    bit              mem_pend;
    logic [63:0]     mem_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts what the DUT must show.
    task automatic cyc(input bit rst_low, input bit redir, input logic [63:0] tgt,
                       input bit rdy, input bit irdy);
        cyc_exp_t e;
        ent_t     ent;
        bit       acc;
        reset          = !rst_low;
        PCSrc_F        = redir;
        PCBranch_F     = tgt;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        imem_rsp_valid = mem_pend;
        imem_rsp_data  = mem_pend ? mem_word(mem_addr) : 32'h0;
        if (rst_low) begin
            e = '{1'b0, 64'h0, 1'b0, 1'b1};
            m_q.delete();
            m_pc       = RST_PC;
            m_inflight = 1'b0;
            m_fetched  = 0;
            m_flushed  = 0;
        end else begin
            e.req_valid  = !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
            e.addr       = m_pc;
            e.inst_valid = (m_q.size() > 0);
            e.zero_chk   = 1'b0;
            if (redir) begin
                m_flushed += longint'(m_q.size()) + longint'(m_inflight);
                m_q.delete();
                m_pc       = tgt;
                m_inflight = 1'b0;
            end else begin
                if (irdy && m_q.size() > 0) deq_q.push_back(m_q.pop_front());
                if (m_inflight) begin
                    ent.pc   = m_inflight_pc;
                    ent.data = mem_word(m_inflight_pc);
                    m_q.push_back(ent);
                end
                acc = e.req_valid && rdy;
                if (acc) begin
                    m_inflight_pc = m_pc;
                    m_pc          = m_pc + 64'(STEP);
                    m_fetched++;
                end
                m_inflight = acc;
            end
        end
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops per-cycle expectations and consumed entries, compares DUT outputs.
    initial begin
        cyc_exp_t e;
        ent_t     x;
        forever begin
            @(negedge clk);
            mem_pend = reset && imem_req_valid && imem_req_ready;
            mem_addr = imem_addr_F;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("req_valid", 64'(imem_req_valid), 64'(e.req_valid));
                chk("inst_valid", 64'(inst_valid), 64'(e.inst_valid));
                if (e.zero_chk) begin
                    chk("rst_inst_data", 64'(inst_data), 64'h0);
                    chk("rst_inst_pc", inst_pc, 64'h0);
                end else begin
                    chk("imem_addr", imem_addr_F, e.addr);
                end
            end
            if (reset && inst_valid && inst_ready && !PCSrc_F) begin
                if (deq_q.size() == 0) begin
                    chk("unexpected_dequeue", 64'h1, 64'h0);
                end else begin
                    x = deq_q.pop_front();
                    chk("inst_pc", inst_pc, x.pc);
                    chk("inst_data", 64'(inst_data), 64'(x.data));
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [63:0] tgt;
        reset = 1'b0; PCSrc_F = 1'b0; PCBranch_F = 64'h0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
        mem_pend = 1'b0; mem_addr = 64'h0;
        m_pc = RST_PC; m_inflight = 1'b0; m_inflight_pc = 64'h0;
        m_fetched = 0; m_flushed = 0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        repeat (12) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 64'h2000, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 64'h3000, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 64'h4000, 1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 64'h10, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            tgt = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hC);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, tgt,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        repeat (12) cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("drain_deq_left", 64'(deq_q.size()), 64'h0);
        chk("drain_model_left", 64'(m_q.size()), 64'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
